mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory access controller sitting directly upstream of the 512-word `ram` block. It accepts single-word read/write requests from the CPU control unit / MAR-MDR datapath through a valid/ready handshake. It sequences the RAM's level-sensitive `address`/`data_in`/`read`/`write` ports with setup, strobe and hold phases so a write never lands on a changing address. It returns read data or completion status through a one-cycle response pulse.

## Interface
- `DATA_W`, 32: data and address width.
- `MEM_DEPTH`, 512: number of valid RAM words; addresses ≥ `MEM_DEPTH` are rejected.
- `WAIT_CYCLES`, 1: strobe-active cycles per access; legal range 1–15.

- `clk`  in  1: single clock, rising edge.
- `clr_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  1: request present.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_addr`  in  32: word address (MAR value).
- `req_wdata`  in  32: write data (MDR value).
- `req_ready`  out  1: controller idle and able to accept.
- `rsp_valid`  out  1: one-cycle completion pulse.
- `rsp_rdata`  out  32: read data; 0 for writes and errors.
- `rsp_err`  out  1: address out of range, qualified by `rsp_valid`.
- `ram_address`  out  32: to RAM `address`.
- `ram_data_in`  out  32: to RAM `data_in`.
- `ram_read`  out  1: to RAM `read`.
- `ram_write`  out  1: to RAM `write`.
- `ram_data_out`  in  32: from RAM `data_out`.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD, RESP.
- IDLE: `req_ready`=1. On `req_valid`:
  - Latch addr, wdata and write flag.
  - If addr ≥ `MEM_DEPTH`, go to RESP with err=1 and issue no strobes.
  - Otherwise go to SETUP.
- SETUP: one cycle. `ram_address` and `ram_data_in` are driven from the latches; strobes low.
- ACCESS: `ram_write` or `ram_read` high for exactly `WAIT_CYCLES` cycles, timed by a down-counter. Reads capture `ram_data_out` on the final ACCESS edge.
- HOLD: one cycle, strobes low, address and data unchanged.
- RESP: `rsp_valid`=1 for one cycle, then IDLE.
- `ram_data_in` = latched wdata on writes and 0 on reads. `ram_address` holds its last value while idle.
- `ram_read` and `ram_write` are never high together and are never high outside ACCESS.
- All outputs are registered; no combinational path from `req_*` to `ram_*`.

## Timing
- Reset: state IDLE. `req_ready`=1 and all other outputs 0 (`rsp_*`, `ram_*` buses and strobes).
- Reset mid-access drops strobes immediately and discards the request; no response is issued.
- Accept edge E0 = edge with `req_valid && req_ready`.
  - SETUP in cycle E0→E1.
  - ACCESS spans E1→E1+W.
  - HOLD follows, then RESP.
  - `rsp_valid` is high in the cycle after edge E0+W+2.
  - `req_ready` returns one cycle later. Throughput is one request per W+4 cycles.
- Error path: `rsp_valid` in the cycle right after E0, then IDLE.
- `req_valid` while `req_ready`=0 is ignored; the requester must hold it until accepted.
- A new request may be accepted on the same edge that `req_ready` returns high.
- Address compare is unsigned over the full 32 bits: 0x1FF is valid, 0x200 and 0xFFFFFFFF are errors.

## Structure
- Shared package `mem_pkg`: state enum `mem_state_t`, `MEM_DEPTH` constant, and the `WAIT_CYCLES` range limit.
- Optional sub-module `mem_wait_timer`: loadable 4-bit down-counter with a `zero` flag; otherwise inline.

## Test plan
- Reset, then read addr 43 (RAM holds 0x2), W=1: `ram_read` high 1 cycle; `rsp_valid` after 3 edges with `rsp_rdata`=0x00000002, `rsp_err`=0.
- Write 0xDEADBEEF to addr 87, then read 87: `ram_write` high only after `ram_address`=87 is stable one cycle; read returns 0xDEADBEEF; `rsp_rdata`=0 on the write response.
- Read addr 0x200: no strobe ever asserts; `rsp_valid`=1 and `rsp_err`=1 the cycle after accept; `rsp_rdata`=0.
- W=3, back-to-back reads of 51 and 95 with `req_valid` held high: second accept on the edge `req_ready` returns; responses 0x7 and 0xD spaced 7 cycles apart.
- Assert `clr_n`=0 during ACCESS of a write: `ram_write` falls immediately, no `rsp_valid`; after release `req_ready`=1 and all outputs are 0.
- Assertion over all runs: `ram_read && ram_write` never true, and `ram_address` never changes while either strobe is high.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and limits for the RAM access controller.
// State encoding, RAM depth and the legal strobe-length window.
package mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_RESP
  } mem_state_t;

  localparam int unsigned MEM_DEPTH = 512;
  localparam int unsigned WAIT_MIN  = 1;
  localparam int unsigned WAIT_MAX  = 15;

  // Timer reload value: strobe length minus one, clamped to the
  // legal window so an out-of-range parameter still behaves.
  function automatic logic [3:0] wait_load(input int unsigned w);
    int unsigned c;
    c = w;
    if (c < WAIT_MIN) c = WAIT_MIN;
    if (c > WAIT_MAX) c = WAIT_MAX;
    return 4'(c - 1);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: loadable 4-bit down-counter with a zero flag.
// Ports: clk, clr_n, i_load, i_load_val[3:0] in; o_zero out.
module mem_wait_timer (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences single-word RAM accesses as
// setup / strobe / hold phases behind a valid/ready request port.
// Ports: clk, clr_n; req_valid/write/addr/wdata in, req_ready out;
// rsp_valid/rdata/err out; ram_address/data_in/read/write out,
// ram_data_out in. All outputs come straight from flops.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_DEPTH   = mem_pkg::MEM_DEPTH,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DATA_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [DATA_W-1:0] ADDR_LIM = DATA_W'(MEM_DEPTH);
  localparam logic [3:0]        LOAD_VAL = wait_load(WAIT_CYCLES);

  mem_state_t        r_state;
  logic              r_wr;
  logic              r_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic              r_ram_rd;
  logic              r_ram_wr;
  logic              w_tmr_load;
  logic              w_tmr_zero;

  // Reload in SETUP so the count covers exactly the ACCESS cycles.
  assign w_tmr_load = (r_state == S_SETUP);

  mem_wait_timer u_timer (
    .clk        (clk),
    .clr_n      (clr_n),
    .i_load     (w_tmr_load),
    .i_load_val (LOAD_VAL),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rdata     <= '0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_ram_rd    <= 1'b0;
      r_ram_wr    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_wr    <= req_write;
            r_ready <= 1'b0;
            if (req_addr >= ADDR_LIM) begin
              // Rejected: RAM bus keeps its previous value.
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state    <= S_SETUP;
              r_ram_addr <= req_addr;
              r_ram_din  <= req_write ? req_wdata : '0;
            end
          end
        end
        S_SETUP: begin
          r_state  <= S_ACCESS;
          r_ram_rd <= ~r_wr;
          r_ram_wr <= r_wr;
        end
        S_ACCESS: begin
          if (w_tmr_zero) begin
            r_state  <= S_HOLD;
            r_ram_rd <= 1'b0;
            r_ram_wr <= 1'b0;
            r_rdata  <= r_wr ? '0 : ram_data_out;
          end
        end
        S_HOLD: begin
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= r_rdata;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_ready     <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_ready  <= 1'b1;
          r_ram_rd <= 1'b0;
          r_ram_wr <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = r_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign rsp_rdata   = r_rsp_rdata;
  assign ram_address = r_ram_addr;
  assign ram_data_in = r_ram_din;
  assign ram_read    = r_ram_rd;
  assign ram_write   = r_ram_wr;

endmodule
